// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter sharing the register bank write port between ALU (A) and load (B) writebacks.
// Optional macro ARB_STALL_STATS_EN enables the saturating stall_cnt contention counter.
module reg_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit ZERO_REG_LOCK = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    input  logic              hold,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              prio_b,
    output logic [15:0]       stall_cnt
);
    logic              xfer, issue, contended;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    always_comb begin
        a_ready   = !rst && !hold && a_valid && (!b_valid || !prio_b);
        b_ready   = !rst && !hold && b_valid && (!a_valid || prio_b);
        xfer      = a_ready || b_ready;
        contended = a_valid && b_valid;
        sel_addr  = a_ready ? a_addr : b_addr;
        sel_data  = a_ready ? a_data : b_data;
        issue     = xfer && !(ZERO_REG_LOCK && sel_addr == '0);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            prio_b  <= 1'b0;
        end else begin
            wr_en <= issue;
            if (issue) begin
                wr_addr <= sel_addr;
                wr_data <= sel_data;
            end
            // the granted port held priority, so toggling hands it to the loser
            if (xfer && contended)
                prio_b <= !prio_b;
        end
    end
`ifdef ARB_STALL_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if ((contended || ((a_valid || b_valid) && hold)) && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`else
    assign stall_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: table-driven checks of grant, latency, round-robin, zero filter, hold and reset.
module tb_reg_write_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic        a_valid = 0, b_valid = 0, hold = 0;
    logic [4:0]  a_addr = 0, b_addr = 0;
    logic [31:0] a_data = 0, b_data = 0;
    logic        a_ready, b_ready, wr_en, prio_b;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [15:0] stall_cnt;
    int checks = 0, errors = 0;
    int exp_stall = 0;

    always #5 clk = ~clk;

    reg_write_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .hold(hold), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .prio_b(prio_b), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic        h;
        logic        ar, br, we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        pb;
    } vec_t;
    vec_t tv[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [31:0] bd, input logic h);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd; hold = h;
`ifdef ARB_STALL_STATS_EN
        if ((av && bv) || ((av || bv) && h)) exp_stall++;
`endif
    endtask

    initial begin
        // av aa ad  bv ba bd  h | ar br we wa wd pb
        tv.push_back('{1, 5, 32'hDEAD_BEEF, 0, 0, 0,            0, 1, 0, 1, 5, 32'hDEAD_BEEF, 0});
        tv.push_back('{0, 0, 0,             0, 0, 0,            0, 0, 0, 0, 5, 32'hDEAD_BEEF, 0});
        tv.push_back('{1, 3, 32'hA1,        1, 7, 32'hB1,       0, 1, 0, 1, 3, 32'hA1, 1});
        tv.push_back('{1, 4, 32'hA2,        1, 7, 32'hB1,       0, 0, 1, 1, 7, 32'hB1, 0});
        tv.push_back('{1, 4, 32'hA2,        1, 8, 32'hB2,       0, 1, 0, 1, 4, 32'hA2, 1});
        tv.push_back('{1, 5, 32'hA3,        1, 8, 32'hB2,       0, 0, 1, 1, 8, 32'hB2, 0});
        tv.push_back('{0, 0, 0,             1, 0, 32'h33,       0, 0, 1, 0, 8, 32'hB2, 0});
        tv.push_back('{1, 9, 32'h99,        0, 0, 0,            1, 0, 0, 0, 8, 32'hB2, 0});
        tv.push_back('{1, 9, 32'h99,        0, 0, 0,            1, 0, 0, 0, 8, 32'hB2, 0});
        tv.push_back('{1, 9, 32'h99,        0, 0, 0,            1, 0, 0, 0, 8, 32'hB2, 0});
        tv.push_back('{1, 9, 32'h99,        0, 0, 0,            0, 1, 0, 1, 9, 32'h99, 0});
        tv.push_back('{0, 0, 0,             1, 10, 32'h1010,    0, 0, 1, 1, 10, 32'h1010, 0});
        tv.push_back('{1, 12, 32'hC1,       1, 12, 32'hC2,      0, 1, 0, 1, 12, 32'hC1, 1});
        tv.push_back('{0, 0, 0,             1, 12, 32'hC2,      0, 0, 1, 1, 12, 32'hC2, 1});
        tv.push_back('{1, 0, 32'hE0,        1, 6, 32'h66,       0, 0, 1, 1, 6, 32'h66, 0});
        tv.push_back('{1, 0, 32'hE0,        0, 0, 0,            0, 1, 0, 0, 6, 32'h66, 0});
        tv.push_back('{1, 13, 32'hD13,      0, 0, 0,            1, 0, 0, 0, 6, 32'h66, 0});
        tv.push_back('{0, 0, 0,             0, 0, 0,            0, 0, 0, 0, 6, 32'h66, 0});

        #2;
        chk("rst_ready", {a_ready, b_ready}, 2'b00);
        chk("rst_state", {wr_en, wr_addr, wr_data, prio_b, stall_cnt}, '0);
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].av, tv[i].aa, tv[i].ad, tv[i].bv, tv[i].ba, tv[i].bd, tv[i].h);
            #1;
            chk($sformatf("v%0d_ready", i), {a_ready, b_ready}, {tv[i].ar, tv[i].br});
            @(posedge clk); #1;
            chk($sformatf("v%0d_wr_en", i), wr_en, tv[i].we);
            chk($sformatf("v%0d_wr_addr", i), wr_addr, tv[i].wa);
            chk($sformatf("v%0d_wr_data", i), wr_data, tv[i].wd);
            chk($sformatf("v%0d_prio_b", i), prio_b, tv[i].pb);
            chk($sformatf("v%0d_stall", i), stall_cnt, exp_stall[15:0]);
        end

        // contended transfer leaves wr_en=1 and prio_b=1; async reset must kill both at once
        drive(1, 20, 32'h2020, 1, 21, 32'h2121, 0);
        @(posedge clk); #1;
        chk("pre_rst_wr_en", wr_en, 1'b1);
        chk("pre_rst_prio", prio_b, 1'b1);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b1;
        exp_stall = 0;
        #1;
        chk("mid_rst_clear", {wr_en, wr_addr, wr_data, prio_b, stall_cnt}, '0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_no_write", wr_en, 1'b0);

`ifdef ARB_STALL_STATS_EN
        drive(1, 1, 0, 1, 2, 0, 1);
        repeat (66000) @(posedge clk);
        #1 chk("stall_sat", stall_cnt, 16'hFFFF);
        @(posedge clk); #1;
        chk("stall_no_wrap", stall_cnt, 16'hFFFF);
        chk("sat_hold_no_write", wr_en, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 0);
`else
        drive(1, 1, 0, 1, 2, 0, 1);
        repeat (20) @(posedge clk);
        #1 chk("stall_tied_zero", stall_cnt, 16'h0000);
        drive(0, 0, 0, 0, 0, 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
